// File: rtl/vga_pkg.sv
// vga_pkg
// Shared definitions for the VGA scan controller:
//   - vga_timing_t and standard timing sets (640x480@60, 800x600@60)
//   - cnt_w / line_w: counter and line-number width helpers
//   - pack_rgb: packs per-channel on/off flags into full-scale {R,G,B}
//   - bar_mask: colour-bar table for the test pattern
// No ports (package).
package vga_pkg;

  typedef struct packed {
    int h_active;
    int h_fp;
    int h_sync;
    int h_bp;
    int v_active;
    int v_fp;
    int v_sync;
    int v_bp;
  } vga_timing_t;

  localparam vga_timing_t VGA_640X480_60 = '{640, 16, 96, 48, 480, 10, 2, 33};
  localparam vga_timing_t VGA_800X600_60 = '{800, 40, 128, 88, 600, 1, 4, 23};

  // Widest colour channel the packing helper supports.
  localparam int MAX_COLOR_W = 16;

  // Bits needed to count 0..total-1 (at least one bit).
  function automatic int cnt_w(input int total);
    return (total > 1) ? $clog2(total) : 1;
  endfunction

  // Line-number output is at least 10 bits wide for compatibility with the
  // fixed 640x480 controller, wider only when the frame needs it.
  function automatic int line_w(input int v_total);
    return (cnt_w(v_total) > 10) ? cnt_w(v_total) : 10;
  endfunction

  // Expands {r,g,b} on/off flags to full-scale channels of width color_w,
  // returned in the low 3*color_w bits as {R,G,B}.
  function automatic logic [3*MAX_COLOR_W-1:0] pack_rgb(input logic [2:0] mask,
                                                          input int color_w);
    logic [3*MAX_COLOR_W-1:0] res;
    res = '0;
    for (int c = 0; c < 3; c++) begin
      for (int b = 0; b < MAX_COLOR_W; b++) begin
        if (b < color_w) res[c*color_w + b] = mask[c];
      end
    end
    return res;
  endfunction

  // Colour-bar table as {r,g,b} on/off flags, left to right:
  // white, yellow, cyan, green, magenta, red, blue, black.
  function automatic logic [2:0] bar_mask(input logic [2:0] idx);
    logic [2:0] m;
    case (idx)
      3'd0:    m = 3'b111;
      3'd1:    m = 3'b110;
      3'd2:    m = 3'b011;
      3'd3:    m = 3'b010;
      3'd4:    m = 3'b101;
      3'd5:    m = 3'b100;
      3'd6:    m = 3'b001;
      default: m = 3'b000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// Horizontal/vertical scan counters and the stage-0 flags derived from them.
// Ports:
//   clk_i          pixel clock
//   srst_i         synchronous active-high reset (counters to 0,0)
//   h_o, v_o       current horizontal / vertical position
//   active_o       position is inside the visible area
//   hs_act_o       position is inside the horizontal sync pulse
//   vs_act_o       line is inside the vertical sync pulse
//   frame_start_o  position is (0,0)
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int H_W     = cnt_w(H_TOTAL),
  localparam int V_W     = cnt_w(V_TOTAL)
) (
  input  logic           clk_i,
  input  logic           srst_i,
  output logic [H_W-1:0] h_o,
  output logic [V_W-1:0] v_o,
  output logic           active_o,
  output logic           hs_act_o,
  output logic           vs_act_o,
  output logic           frame_start_o
);

  localparam int HW1 = H_W + 1;
  localparam int VW1 = V_W + 1;

  localparam logic [H_W-1:0] H_LAST = H_W'(H_TOTAL - 1);
  localparam logic [V_W-1:0] V_LAST = V_W'(V_TOTAL - 1);

  // Thresholds carry one extra bit: the sync end can equal the total, which
  // does not fit the counter width when the total is a power of two.
  localparam logic [H_W:0] HA_X  = HW1'(H_ACTIVE);
  localparam logic [H_W:0] HS0_X = HW1'(H_ACTIVE + H_FP);
  localparam logic [H_W:0] HS1_X = HW1'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [V_W:0] VA_X  = VW1'(V_ACTIVE);
  localparam logic [V_W:0] VS0_X = VW1'(V_ACTIVE + V_FP);
  localparam logic [V_W:0] VS1_X = VW1'(V_ACTIVE + V_FP + V_SYNC);

  logic [H_W-1:0] h_q, h_d;
  logic [V_W-1:0] v_q, v_d;
  logic [H_W:0]   h_x;
  logic [V_W:0]   v_x;

  always_comb begin
    h_d = h_q + H_W'(1);
    v_d = v_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + V_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  assign h_x = {1'b0, h_q};
  assign v_x = {1'b0, v_q};

  assign h_o           = h_q;
  assign v_o           = v_q;
  assign active_o      = (h_x < HA_X) && (v_x < VA_X);
  assign hs_act_o      = (h_x >= HS0_X) && (h_x < HS1_X);
  assign vs_act_o      = (v_x >= VS0_X) && (v_x < VS1_X);
  assign frame_start_o = (h_q == '0) && (v_q == '0);

endmodule

// File: rtl/vga_scan_controller.sv
// vga_scan_controller
// Parametrised VGA scan controller: generates sync/blank from configurable
// timing, issues frame-buffer read addresses (with 2^SCALE_SHIFT pixel
// replication), and realigns the returned pixel data so sync, blank and
// colour leave the block together, RD_LAT+2 clocks after the scan counters.
// Optional build macro: VGA_TEST_PATTERN_EN adds input iTEST, which replaces
// iRGB with eight full-scale vertical colour bars.
// Ports:
//   iVGA_CLK      pixel clock
//   iRST          synchronous active-high reset
//   oADDR         frame-buffer read address (0 outside the visible area)
//   iRGB          pixel data {R,G,B}, valid RD_LAT clocks after oADDR
//   iTEST         (VGA_TEST_PATTERN_EN only) select colour-bar pattern
//   oHS, oVS      sync outputs, active level HS_POL / VS_POL
//   oBLANK_n      high during visible pixels
//   oR, oG, oB    colour, 0 when blanked
//   oFRAME_START  one-clock pulse with output pixel (0,0)
//   oLINE         line number of the pixel currently on the outputs
module vga_scan_controller
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE    = 640,
  parameter int   H_FP        = 16,
  parameter int   H_SYNC      = 96,
  parameter int   H_BP        = 48,
  parameter int   V_ACTIVE    = 480,
  parameter int   V_FP        = 10,
  parameter int   V_SYNC      = 2,
  parameter int   V_BP        = 33,
  parameter logic HS_POL      = 1'b0,
  parameter logic VS_POL      = 1'b0,
  parameter int   COLOR_W     = 8,
  parameter int   ADDR_W      = 19,
  parameter int   SCALE_SHIFT = 0,
  parameter int   RD_LAT      = 1,
  localparam int  V_TOTAL     = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int  LINE_W      = line_w(V_TOTAL)
) (
  input  logic                 iVGA_CLK,
  input  logic                 iRST,
  output logic [ADDR_W-1:0]    oADDR,
  input  logic [3*COLOR_W-1:0] iRGB,
`ifdef VGA_TEST_PATTERN_EN
  input  logic                 iTEST,
`endif
  output logic                 oHS,
  output logic                 oVS,
  output logic                 oBLANK_n,
  output logic [COLOR_W-1:0]   oR,
  output logic [COLOR_W-1:0]   oG,
  output logic [COLOR_W-1:0]   oB,
  output logic                 oFRAME_START,
  output logic [LINE_W-1:0]    oLINE
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int H_W     = cnt_w(H_TOTAL);
  localparam int V_W     = cnt_w(V_TOTAL);
  localparam int PIPE    = RD_LAT + 2;
  localparam int SCALE   = 1 << SCALE_SHIFT;

  // ---------------------------------------------------------------- checks
  if ((H_ACTIVE % SCALE) != 0 || (V_ACTIVE % SCALE) != 0) begin : g_err_scale
    $error("H_ACTIVE and V_ACTIVE must be multiples of 2^SCALE_SHIFT");
  end
  if (RD_LAT < 1) begin : g_err_lat
    $error("RD_LAT must be at least 1");
  end
  if (ADDR_W < 1 || ADDR_W > 32) begin : g_err_aw
    $error("ADDR_W must be in 1..32");
  end
  if ((longint'(V_ACTIVE / SCALE) * longint'(H_ACTIVE / SCALE)) >
      (longint'(1) << ADDR_W)) begin : g_err_fit
    $error("scaled frame does not fit in ADDR_W address bits");
  end
  if (COLOR_W < 1 || COLOR_W > MAX_COLOR_W) begin : g_err_cw
    $error("COLOR_W out of supported range");
  end

  // --------------------------------------------------------------- stage 0
  logic [H_W-1:0] h_s0;
  logic [V_W-1:0] v_s0;
  logic           active_s0;
  logic           hs_s0;
  logic           vs_s0;
  logic           fs_s0;

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk_i         (iVGA_CLK),
    .srst_i        (iRST),
    .h_o           (h_s0),
    .v_o           (v_s0),
    .active_o      (active_s0),
    .hs_act_o      (hs_s0),
    .vs_act_o      (vs_s0),
    .frame_start_o (fs_s0)
  );

  // ------------------------------------------------------- address stage
  logic [ADDR_W-1:0] addr_q, addr_d;

  always_comb begin
    addr_d = '0;
    if (active_s0) begin
      addr_d = ADDR_W'(32'(v_s0 >> SCALE_SHIFT) * 32'(H_ACTIVE >> SCALE_SHIFT)
                       + 32'(h_s0 >> SCALE_SHIFT));
    end
  end

  always_ff @(posedge iVGA_CLK) begin
    if (iRST) addr_q <= '0;
    else      addr_q <= addr_d;
  end

  assign oADDR = addr_q;

  // ------------------------------------------------------------ delay line
  // Entry k holds the stage-0 flags from k+1 clocks ago. Entry PIPE-1 drives
  // the pins; entry PIPE-2 lines up with iRGB for the colour register.
  logic [PIPE-1:0]   act_q, hs_q, vs_q, fs_q;
  logic [LINE_W-1:0] line_q [PIPE];
  logic [LINE_W-1:0] line_d [PIPE];

  always_ff @(posedge iVGA_CLK) begin
    if (iRST) begin
      act_q <= '0;
      hs_q  <= '0;
      vs_q  <= '0;
      fs_q  <= '0;
    end else begin
      act_q <= {act_q[PIPE-2:0], active_s0};
      hs_q  <= {hs_q[PIPE-2:0],  hs_s0};
      vs_q  <= {vs_q[PIPE-2:0],  vs_s0};
      fs_q  <= {fs_q[PIPE-2:0],  fs_s0};
    end
  end

  for (genvar gi = 0; gi < PIPE; gi++) begin : g_line
    if (gi == 0) begin : g_head
      assign line_d[gi] = LINE_W'(v_s0);
    end else begin : g_tail
      assign line_d[gi] = line_q[gi-1];
    end
  end

  always_ff @(posedge iVGA_CLK) begin
    if (iRST) line_q <= '{default: '0};
    else      line_q <= line_d;
  end

`ifdef VGA_TEST_PATTERN_EN
  // Bar index only needs to reach the colour register, so this line is one
  // entry shorter than the flag pipe.
  logic [2:0] bar_s0;
  logic [2:0] bar_q [PIPE-1];
  logic [2:0] bar_d [PIPE-1];
  logic [2:0] bar_m;

  // Values beyond the visible width are never used: the pixel is blanked.
  assign bar_s0 = 3'((32'(h_s0) * 32'd8) / 32'(H_ACTIVE));

  for (genvar gi = 0; gi < PIPE - 1; gi++) begin : g_bar
    if (gi == 0) begin : g_head
      assign bar_d[gi] = bar_s0;
    end else begin : g_tail
      assign bar_d[gi] = bar_q[gi-1];
    end
  end

  always_ff @(posedge iVGA_CLK) begin
    if (iRST) bar_q <= '{default: '0};
    else      bar_q <= bar_d;
  end

  assign bar_m = bar_mask(bar_q[PIPE-2]);
`endif

  // ---------------------------------------------------------- colour stage
  logic [3*COLOR_W-1:0] rgb_q, rgb_d;

  always_comb begin
    rgb_d = '0;
    if (act_q[PIPE-2]) begin
`ifdef VGA_TEST_PATTERN_EN
      if (iTEST) rgb_d = pack_rgb(bar_m, COLOR_W)[3*COLOR_W-1:0];
      else       rgb_d = iRGB;
`else
      rgb_d = iRGB;
`endif
    end
  end

  always_ff @(posedge iVGA_CLK) begin
    if (iRST) rgb_q <= '0;
    else      rgb_q <= rgb_d;
  end

  // --------------------------------------------------------------- outputs
  assign oHS          = hs_q[PIPE-1] ? HS_POL : ~HS_POL;
  assign oVS          = vs_q[PIPE-1] ? VS_POL : ~VS_POL;
  assign oBLANK_n     = act_q[PIPE-1];
  assign oFRAME_START = fs_q[PIPE-1];
  assign oLINE        = line_q[PIPE-1];
  assign {oR, oG, oB} = rgb_q;

endmodule

// File: tb/tb_vga_scan_controller.sv
// tb_vga_scan_controller
// Three instances of the controller on small timing (H 8/2/2/2, V 4/1/1/1):
//   d0: RD_LAT=1, SCALE_SHIFT=0   d1: RD_LAT=1, SCALE_SHIFT=1
//   d3: RD_LAT=3, SCALE_SHIFT=0
// Each gets a RAM model returning {8'hA5, addr[15:0]} RD_LAT clocks after
// oADDR. A position-based model predicts every output from k, the number of
// clocks since the last reset edge; directed literal checks pin the model.
module tb_vga_scan_controller;

  localparam int HA = 8, HFP = 2, HSW = 2, HBP = 2;
  localparam int VA = 4, VFP = 1, VSW = 1, VBP = 1;
  localparam int HT = HA + HFP + HSW + HBP;   // 14
  localparam int VT = VA + VFP + VSW + VBP;   // 7

  logic clk = 1'b0;
  logic iRST = 1'b1;
  always #5 clk = ~clk;

  int k = 0;
  bit started = 1'b0;
  int vectors = 0;
  int miscompares = 0;

  always @(posedge clk) begin
    if (iRST) begin
      k       <= 0;
      started <= 1'b1;
    end else begin
      k <= k + 1;
    end
  end

  // ------------------------------------------------------------ instances
  logic [18:0] a0, a1, a3;
  logic [23:0] rgb_in0, rgb_in1, rgb_in3;
  logic        hs0, vs0, bl0, fs0, hs1, vs1, bl1, fs1, hs3, vs3, bl3, fs3;
  logic [7:0]  r0, g0, b0, r1, g1, b1, r3, g3, b3;
  logic [9:0]  ln0, ln1, ln3;
`ifdef VGA_TEST_PATTERN_EN
  logic test_sel = 1'b0;
`endif

  vga_scan_controller #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .HS_POL(1'b0), .VS_POL(1'b0), .COLOR_W(8), .ADDR_W(19),
    .SCALE_SHIFT(0), .RD_LAT(1)
  ) d0 (
    .iVGA_CLK(clk), .iRST(iRST), .oADDR(a0), .iRGB(rgb_in0),
`ifdef VGA_TEST_PATTERN_EN
    .iTEST(test_sel),
`endif
    .oHS(hs0), .oVS(vs0), .oBLANK_n(bl0), .oR(r0), .oG(g0), .oB(b0),
    .oFRAME_START(fs0), .oLINE(ln0)
  );

  vga_scan_controller #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .HS_POL(1'b0), .VS_POL(1'b0), .COLOR_W(8), .ADDR_W(19),
    .SCALE_SHIFT(1), .RD_LAT(1)
  ) d1 (
    .iVGA_CLK(clk), .iRST(iRST), .oADDR(a1), .iRGB(rgb_in1),
`ifdef VGA_TEST_PATTERN_EN
    .iTEST(test_sel),
`endif
    .oHS(hs1), .oVS(vs1), .oBLANK_n(bl1), .oR(r1), .oG(g1), .oB(b1),
    .oFRAME_START(fs1), .oLINE(ln1)
  );

  vga_scan_controller #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .HS_POL(1'b0), .VS_POL(1'b0), .COLOR_W(8), .ADDR_W(19),
    .SCALE_SHIFT(0), .RD_LAT(3)
  ) d3 (
    .iVGA_CLK(clk), .iRST(iRST), .oADDR(a3), .iRGB(rgb_in3),
`ifdef VGA_TEST_PATTERN_EN
    .iTEST(test_sel),
`endif
    .oHS(hs3), .oVS(vs3), .oBLANK_n(bl3), .oR(r3), .oG(g3), .oB(b3),
    .oFRAME_START(fs3), .oLINE(ln3)
  );

  // ------------------------------------------------------------ RAM models
  logic [18:0] rd0, rd1;
  logic [18:0] rd3 [3];

  always @(posedge clk) begin
    rd0    <= a0;
    rd1    <= a1;
    rd3[0] <= a3;
    rd3[1] <= rd3[0];
    rd3[2] <= rd3[1];
  end

  assign rgb_in0 = {8'hA5, rd0[15:0]};
  assign rgb_in1 = {8'hA5, rd1[15:0]};
  assign rgb_in3 = {8'hA5, rd3[2][15:0]};

  // ------------------------------------------------------------ model
  function automatic int pix_addr(input int h, input int v, input int s);
    return (v >> s) * (HA >> s) + (h >> s);
  endfunction

  // Expected {oADDR, oHS, oVS, oBLANK_n, oFRAME_START, R, G, B, oLINE}.
  // oADDR shows scan position k-1; the pins show position k-(lat+2).
  function automatic logic [56:0] model(input int kk, input int lat, input int s);
    int pipe, p, h, v;
    logic [18:0] a;
    logic hs, vs, bl, fs;
    logic [23:0] rgb;
    logic [9:0] ln;
    pipe = lat + 2;
    a = '0; hs = 1'b1; vs = 1'b1; bl = 1'b0; fs = 1'b0; rgb = '0; ln = '0;
    if (kk >= 1) begin
      p = kk - 1; h = p % HT; v = (p / HT) % VT;
      if (h < HA && v < VA) a = 19'(pix_addr(h, v, s));
    end
    if (kk >= pipe) begin
      p  = kk - pipe; h = p % HT; v = (p / HT) % VT;
      bl = (h < HA) && (v < VA);
      hs = !(h >= HA + HFP && h < HA + HFP + HSW);
      vs = !(v >= VA + VFP && v < VA + VFP + VSW);
      fs = (h == 0) && (v == 0);
      if (bl) rgb = {8'hA5, 16'(pix_addr(h, v, s))};
      ln = 10'(v);
    end
    return {a, hs, vs, bl, fs, rgb, ln};
  endfunction

  task automatic chk_vec(input string name, input logic [56:0] exp_v,
                         input logic [56:0] act_v);
    vectors++;
    if (act_v !== exp_v) begin
      miscompares++;
      $display("FAIL %s k=%0d got %h required %h", name, k, act_v, exp_v);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      chk_vec("model_d0", model(k, 1, 0),
              {a0, hs0, vs0, bl0, fs0, r0, g0, b0, ln0});
      chk_vec("model_d1", model(k, 1, 1),
              {a1, hs1, vs1, bl1, fs1, r1, g1, b1, ln1});
      chk_vec("model_d3", model(k, 3, 0),
              {a3, hs3, vs3, bl3, fs3, r3, g3, b3, ln3});
    end
  end

  // ------------------------------------------------------- directed checks
  task automatic lit(input string name, input logic [31:0] act_v,
                     input logic [31:0] exp_v);
    vectors++;
    if (act_v !== exp_v) begin
      miscompares++;
      $display("FAIL %s k=%0d got %0h required %0h", name, k, act_v, exp_v);
    end
  endtask

  task automatic wait_k(input int target);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (k != target && n < 2000);
    if (k != target) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_k got k=%0d required %0d", k, target);
    end
  endtask

  initial begin
    iRST = 1'b1;
    repeat (3) @(negedge clk);
    iRST = 1'b0;                      // k==0: stage 0 sits at (0,0)

    wait_k(2);
    lit("blank_before_pipe", 32'(bl0), 32'd0);
    lit("hs_idle_after_rst", 32'(hs0), 32'd1);
    lit("vs_idle_after_rst", 32'(vs0), 32'd1);
    wait_k(3);
    lit("blank_rise_pipe3",  32'(bl0), 32'd1);
    lit("fs_with_blank",     32'(fs0), 32'd1);
    wait_k(4);
    lit("fs_one_clock",      32'(fs0), 32'd0);
    lit("blank_lat3_early",  32'(bl3), 32'd0);
    wait_k(5);
    lit("blank_rise_pipe5",  32'(bl3), 32'd1);
    lit("fs_lat3",           32'(fs3), 32'd1);
    wait_k(8);
    lit("scale_addr_l0_c7",  32'(a1), 32'd3);
    wait_k(11);
    lit("blank_colour_r",    32'(r0), 32'd0);
    wait_k(12);
    lit("hs_before_pulse",   32'(hs0), 32'd1);
    wait_k(13);
    lit("hs_low_h10",        32'(hs0), 32'd0);
    wait_k(14);
    lit("hs_low_h11",        32'(hs0), 32'd0);
    wait_k(15);
    lit("hs_high_h12",       32'(hs0), 32'd1);
    lit("hs_lat3_h10",       32'(hs3), 32'd0);
    wait_k(18);
    lit("scale_addr_l1_c3",  32'(a1), 32'd1);
    wait_k(22);
    lit("scale_addr_l1_c7",  32'(a1), 32'd3);
    wait_k(29);
    lit("scale_addr_l2_c0",  32'(a1), 32'd4);
    wait_k(34);
    lit("pix_l2_c3_b",       32'(b0), 32'd19);
    lit("pix_l2_c3_r",       32'(r0), 32'hA5);
    lit("pix_l2_line",       32'(ln0), 32'd2);
    wait_k(36);
    lit("pix_l2_c3_b_lat3",  32'(b3), 32'd19);
    wait_k(72);
    lit("vs_high_line4",     32'(vs0), 32'd1);
    wait_k(73);
    lit("vs_low_line5",      32'(vs0), 32'd0);
    wait_k(86);
    lit("vs_low_line5_end",  32'(vs0), 32'd0);
    wait_k(87);
    lit("vs_high_line6",     32'(vs0), 32'd1);
    wait_k(100);
    lit("fs_not_early",      32'(fs0), 32'd0);
    wait_k(101);
    lit("fs_frame_period",   32'(fs0), 32'd1);

    // Second frame: stage 0 at v=2, h=5 when k=131.
    wait_k(131);
    lit("active_before_rst", 32'(bl0), 32'd1);
    iRST = 1'b1;
    @(negedge clk);
    lit("midrst_blank",      32'(bl0), 32'd0);
    lit("midrst_addr",       32'(a0),  32'd0);
    lit("midrst_hs",         32'(hs0), 32'd1);
    lit("midrst_vs",         32'(vs0), 32'd1);
    lit("midrst_rgb",        32'({r0, g0, b0}), 32'd0);
    lit("midrst_blank_lat3", 32'(bl3), 32'd0);
    iRST = 1'b0;
    wait_k(2);
    lit("midrst_fs_early",   32'(fs0), 32'd0);
    wait_k(3);
    lit("midrst_fs",         32'(fs0), 32'd1);
    lit("midrst_blank_up",   32'(bl0), 32'd1);
    wait_k(5);
    lit("midrst_fs_lat3",    32'(fs3), 32'd1);
    wait_k(110);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
